// File: rtl/fpu_divide_iterative.sv
// fpu_divide_iterative: multi-cycle restoring divider for single-precision
// mantissas. Produces an unrounded fpu_result_t (sign, exponent, 24-bit
// mantissa, 3 guard bits, round mode) for the downstream rounding stage.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both 1. operand_ready is high only in IDLE; result_valid is high only
// in DONE, and result/overflow/underflow hold steady until result_ready.
//
// Optional build macro FPU_DIVIDE_EARLY_OUT_EN: when defined, a divisor
// mantissa of exactly 24'h800000 bypasses the iteration and the result is
// presented the cycle after the operand handshake.
`timescale 1ns/1ps

package fpu_divide_iterative_pkg;

    typedef enum logic [2:0] {
        RM_RNE = 3'd0,
        RM_RTZ = 3'd1,
        RM_RDN = 3'd2,
        RM_RUP = 3'd3,
        RM_RMM = 3'd4
    } fpu_round_mode_t;

    typedef struct packed {
        logic            sign;
        logic [7:0]      exponent;
        logic [23:0]     mantissa;
        logic [2:0]      guard;
        fpu_round_mode_t round_mode;
    } fpu_result_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } fpu_div_state_t;

endpackage

module fpu_divide_iterative
    import fpu_divide_iterative_pkg::*;
#(
    parameter int RADIX_BITS = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            operand_valid,
    output logic            operand_ready,
    input  logic            a_sign,
    input  logic [7:0]      a_exponent,
    input  logic [23:0]     a_mantissa,
    input  logic            b_sign,
    input  logic [7:0]      b_exponent,
    input  logic [23:0]     b_mantissa,
    input  fpu_round_mode_t round_mode,
    output logic            result_valid,
    input  logic            result_ready,
    output fpu_result_t     result,
    output logic            overflow,
    output logic            underflow,
    output fpu_div_state_t  fsm_state
);

    localparam int ITER = 26 / RADIX_BITS;
    localparam logic [4:0] ITER_CNT = 5'(ITER);

    generate
        if (RADIX_BITS != 1 && RADIX_BITS != 2) begin : g_bad_radix
            $error("fpu_divide_iterative: RADIX_BITS must be 1 or 2");
        end
    endgenerate

    fpu_div_state_t state_q;
    fpu_div_state_t state_d;

    // Iteration datapath registers. The partial remainder stays below twice
    // the divisor for legal operands, so 26 bits leave headroom.
    logic [25:0]        rem_q;
    logic [23:0]        div_q;
    logic [25:0]        quo_q;
    logic [4:0]         cnt_q;
    logic signed [9:0]  exp_q;
    logic               sign_q;
    fpu_round_mode_t    rmode_q;

    fpu_result_t        result_q;
    logic               overflow_q;
    logic               underflow_q;

    // Capture-time values
    logic               a_lt_b;
    logic [25:0]        cap_rem;
    logic signed [9:0]  cap_exp;
    logic signed [9:0]  early_exp;
    logic               early_out;

    // One BUSY cycle worth of quotient retirement
    logic [25:0]        it_rem;
    logic [25:0]        it_quo;

    // Pack quotient and exponent into the rounding-stage format, applying
    // exponent saturation / flush-to-zero.
    function automatic fpu_result_t pack_result(
        input logic              sign,
        input logic signed [9:0] e,
        input logic [25:0]       q,
        input logic              sticky,
        input fpu_round_mode_t   rm
    );
        fpu_result_t r;
        r.sign       = sign;
        r.round_mode = rm;
        if (e >= 10'sd255) begin
            r.exponent = 8'hFF;
            r.mantissa = '0;
            r.guard    = '0;
        end else if (e <= 10'sd0) begin
            r.exponent = 8'h00;
            r.mantissa = '0;
            r.guard    = '0;
        end else begin
            r.exponent = e[7:0];
            r.mantissa = q[25:2];
            r.guard    = {q[1], q[0], sticky};
        end
        return r;
    endfunction

    function automatic logic is_overflow(input logic signed [9:0] e);
        return (e >= 10'sd255);
    endfunction

    function automatic logic is_underflow(input logic signed [9:0] e);
        return (e <= 10'sd0);
    endfunction

    // Operand pre-alignment: when a < b the dividend is doubled so the first
    // quotient bit is always 1, and the exponent is adjusted to compensate.
    always_comb begin
        a_lt_b    = (a_mantissa < b_mantissa);
        cap_rem   = a_lt_b ? {1'b0, a_mantissa, 1'b0} : {2'b00, a_mantissa};
        cap_exp   = $signed({2'b00, a_exponent}) - $signed({2'b00, b_exponent})
                    + 10'sd127 - (a_lt_b ? 10'sd1 : 10'sd0);
        early_exp = $signed({2'b00, a_exponent}) - $signed({2'b00, b_exponent})
                    + 10'sd127;
    end

`ifdef FPU_DIVIDE_EARLY_OUT_EN
    // Power-of-two divisor: the quotient mantissa is the dividend mantissa.
    assign early_out = (b_mantissa == 24'h800000);
`else
    assign early_out = 1'b0;
`endif

    // Restoring division step, repeated RADIX_BITS times, MSB first.
    always_comb begin
        it_rem = rem_q;
        it_quo = quo_q;
        for (int i = 0; i < RADIX_BITS; i++) begin
            if (it_rem >= {2'b00, div_q}) begin
                it_rem = it_rem - {2'b00, div_q};
                it_quo = {it_quo[24:0], 1'b1};
            end else begin
                it_quo = {it_quo[24:0], 1'b0};
            end
            it_rem = {it_rem[24:0], 1'b0};
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (operand_valid) begin
                    state_d = early_out ? ST_DONE : ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (cnt_q == ITER_CNT) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (result_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        operand_ready = 1'b0;
        result_valid  = 1'b0;
        case (state_q)
            ST_IDLE: operand_ready = 1'b1;
            ST_DONE: result_valid  = 1'b1;
            default: ;
        endcase
    end

    // Datapath: capture in IDLE, iterate in BUSY, pack on the way to DONE,
    // hold everything while DONE waits for result_ready.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rem_q       <= '0;
            div_q       <= '0;
            quo_q       <= '0;
            cnt_q       <= '0;
            exp_q       <= '0;
            sign_q      <= 1'b0;
            rmode_q     <= RM_RNE;
            result_q    <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (operand_valid) begin
                        sign_q  <= a_sign ^ b_sign;
                        exp_q   <= cap_exp;
                        rem_q   <= cap_rem;
                        div_q   <= b_mantissa;
                        quo_q   <= '0;
                        cnt_q   <= '0;
                        rmode_q <= round_mode;
                        if (early_out) begin
                            result_q    <= pack_result(a_sign ^ b_sign, early_exp,
                                                       {a_mantissa, 2'b00}, 1'b0,
                                                       round_mode);
                            overflow_q  <= is_overflow(early_exp);
                            underflow_q <= is_underflow(early_exp);
                        end
                    end
                end
                ST_BUSY: begin
                    if (cnt_q != ITER_CNT) begin
                        rem_q <= it_rem;
                        quo_q <= it_quo;
                        cnt_q <= cnt_q + 5'd1;
                    end else begin
                        result_q    <= pack_result(sign_q, exp_q, quo_q,
                                                   (rem_q != '0), rmode_q);
                        overflow_q  <= is_overflow(exp_q);
                        underflow_q <= is_underflow(exp_q);
                    end
                end
                default: ;
            endcase
        end
    end

    assign result    = result_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;
    assign fsm_state = state_q;

endmodule
